formula_distributor_inorder: RTL and testbench
==============================================

# formula_distributor_inorder

Parametrised task distributor for the isqrt formula blocks. It accepts one (a, b, c) triple per cycle through a valid/ready handshake and dispatches each triple round-robin to one of N_WORKERS FSM-based formula instances. It returns results strictly in issue order through a second valid/ready handshake, and stalls the input when the next slot is still occupied. It replaces the fixed 50-instance distributor: it adds depth control, backpressure on both sides, and an occupancy count.

## Interface
- FORMULA, default 1: 1 selects formula_1_impl_*_top, 2 selects formula_2_top.
- IMPL, default 1: formula-1 implementation (1 or 2); ignored when FORMULA=2.
- N_WORKERS, default 8: worker slot count, ≥2, need not be a power of two.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- arg_vld  in  1  triple valid.
- arg_rdy  out  1  distributor can accept; transfer when arg_vld & arg_rdy.
- a, b, c  in  32 each  arguments, sampled on transfer.
- res_vld  out  1  in-order result available.
- res_rdy  in  1  consumer accepts; retire when res_vld & res_rdy.
- res  out  32  result; valid only while res_vld=1, held stable until retired.
- in_flight  out  $clog2(N_WORKERS+1)  number of slots not IDLE.

## Operation
- Each slot has three states: IDLE, BUSY, DONE.
  - IDLE→BUSY on transfer while issue_ptr==slot. The slot registers a/b/c and pulses its worker arg_vld for exactly 1 cycle on the cycle after transfer.
  - BUSY→DONE on worker res_vld; the slot captures the worker's res.
  - DONE→IDLE on retire while retire_ptr==slot.
- issue_ptr advances by 1 on each transfer; retire_ptr advances by 1 on each retire. Both wrap N_WORKERS-1→0.
- arg_rdy = (slot[issue_ptr]==IDLE). It is a function of state only and never depends on arg_vld.
- res_vld = (slot[retire_ptr]==DONE); res = that slot's captured result. There is no combinational path from res_rdy to res_vld.
- in_flight is registered: +1 on transfer, −1 on retire, unchanged when both or neither occur.
- Full condition: all slots non-IDLE ⇒ arg_rdy=0 and in_flight=N_WORKERS. Empty condition: in_flight=0 ⇒ res_vld=0.
- Worker res_vld while the slot is not BUSY is ignored.
- Workers finishing out of order is legal. A DONE slot waits until retire_ptr reaches it.
- Reset mid-operation: all slots IDLE, both pointers 0, in_flight 0, workers reset. In-flight tasks are discarded and no stale res_vld appears afterwards.

## Timing
- Values during and after reset: arg_rdy=0 during any cycle rst=1, then 1 the cycle after rst drops; res_vld=0; res=0; in_flight=0.
- Latency, with L = worker cycles from arg_vld to res_vld:
  - transfer at cycle T;
  - worker arg_vld at T+1;
  - worker res_vld at T+1+L;
  - res_vld=1 at T+2+L, when res_rdy is held high and earlier tasks have retired.
- Slot reuse: a slot retired at cycle R is IDLE at R+1 and can accept a new transfer at R+1.
- Throughput: sustained 1 triple/cycle with res_rdy=1 requires N_WORKERS ≥ L+3. Smaller depths stall through arg_rdy, without loss or reordering.
- Simultaneous transfer and retire on the same cycle are independent, including when issue_ptr==retire_ptr (full case: retire frees the slot, but arg_rdy was 0 that cycle).

## Structure
- Shared package formula_distributor_pkg:
  - DATA_W=32;
  - slot_state_t enum {IDLE, BUSY, DONE};
  - function ptr_next(ptr, n) for the wrap rule.
- Sub-module formula_worker_slot, one per slot, generated N_WORKERS times. It contains:
  - the argument registers;
  - the slot FSM;
  - the result register;
  - the FORMULA/IMPL-selected worker instance (generate-if).
- The top holds the pointers, the in_flight counter, and the arg_rdy/res_vld/res muxes.

## Test plan
- Reset behaviour: FORMULA=1, N_WORKERS=8, single triple a=4,b=9,c=16 → one res_vld with res=9; in_flight rises to 1 then returns to 0; arg_rdy stays 1.
- Formula 2: FORMULA=2, triple a=6,b=6,c=9 → res=3.
- Full rate: N_WORKERS=L+3, 100 back-to-back random triples, res_rdy=1 → arg_rdy never deasserts; results match the reference model in order.
- Stall: N_WORKERS=4, res_rdy=0, 6 triples offered → exactly 4 accepted, arg_rdy=0, in_flight=4, res held stable. Then res_rdy=1 → remaining 2 accepted and all 6 retired in order.
- Random backpressure: random arg_vld and res_rdy toggling (50%) with N_WORKERS=5 (non-power-of-two wrap) → no loss, duplication or reordering; res stable while res_vld & !res_rdy.
- Reset mid-operation: rst asserted with 3 tasks in flight → the next cycle shows res_vld=0 and in_flight=0. No res_vld appears for 2L cycles afterwards, and a new triple a=1,b=1,c=1 (FORMULA=1) → res=3.

Source files
------------

// File: rtl/formula_distributor_pkg.sv
// Shared types and helpers for the in-order isqrt formula distributor.
package formula_distributor_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} slot_state_t;
   typedef enum logic [1:0] {W_IDLE, W_STEP1, W_STEP2} worker_state_t;

   function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned n);
      return (ptr >= n - 1) ? 0 : ptr + 1;
   endfunction

   // Greedy bit-by-bit floor square root of a 32-bit value.
   function automatic logic [15:0] isqrt(input logic [31:0] x);
      logic [15:0] r;
      logic [15:0] t;
      logic [31:0] sq;
      r = '0;
      for (int i = 15; i >= 0; i--) begin
         t  = r | (16'd1 << i);
         sq = 32'(t) * 32'(t);
         if (sq <= x) r = t;
      end
      return r;
   endfunction

endpackage

// File: rtl/formula_worker.sv
// FSM-based formula evaluator: FORMULA=1 is isqrt(a)+isqrt(b)+isqrt(c),
// FORMULA=2 is isqrt(a+isqrt(b+isqrt(c))). IMPL=1 of formula 1 is single-cycle.
module formula_worker
   import formula_distributor_pkg::*;
#(
   parameter int unsigned FORMULA = 1,
   parameter int unsigned IMPL    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arg_vld,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   output logic              res_vld,
   output logic [DATA_W-1:0] res
);

   if (FORMULA == 1 && IMPL == 1) begin : g_parallel
      always_ff @(posedge clk) begin
         if (rst) begin
            res_vld <= 1'b0;
            res     <= '0;
         end else begin
            res_vld <= arg_vld;
            if (arg_vld) res <= 32'(isqrt(a)) + 32'(isqrt(b)) + 32'(isqrt(c));
         end
      end
   end else begin : g_seq
      worker_state_t     st_q, st_d;
      logic [DATA_W-1:0] acc_q, acc_d, res_q, res_d, root_in, step_val;
      logic              vld_q, vld_d;

      // Operands are read straight from the slot's argument registers, which hold while busy.
      always_comb begin
         case (st_q)
            W_STEP1: root_in = (FORMULA == 2) ? b + acc_q : b;
            W_STEP2: root_in = (FORMULA == 2) ? a + acc_q : c;
            default: root_in = (FORMULA == 2) ? c : a;
         endcase
         step_val = (FORMULA == 2 || st_q == W_IDLE) ? 32'(isqrt(root_in))
                                                    : acc_q + 32'(isqrt(root_in));
         st_d  = st_q;
         acc_d = acc_q;
         res_d = res_q;
         vld_d = 1'b0;
         case (st_q)
            W_IDLE: begin
               if (arg_vld) begin
                  acc_d = step_val;
                  st_d  = W_STEP1;
               end
            end
            W_STEP1: begin
               acc_d = step_val;
               st_d  = W_STEP2;
            end
            W_STEP2: begin
               res_d = step_val;
               vld_d = 1'b1;
               st_d  = W_IDLE;
            end
            default: st_d = W_IDLE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            st_q  <= W_IDLE;
            acc_q <= '0;
            res_q <= '0;
            vld_q <= 1'b0;
         end else begin
            st_q  <= st_d;
            acc_q <= acc_d;
            res_q <= res_d;
            vld_q <= vld_d;
         end
      end

      assign res_vld = vld_q;
      assign res     = res_q;
   end

endmodule

// File: rtl/formula_worker_slot.sv
// One distributor slot: argument registers, IDLE/BUSY/DONE FSM, result register and worker.
module formula_worker_slot
   import formula_distributor_pkg::*;
#(
   parameter int unsigned FORMULA = 1,
   parameter int unsigned IMPL    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              retire,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   output slot_state_t       state,
   output logic [DATA_W-1:0] res
);

   slot_state_t       state_q, state_d;
   logic [DATA_W-1:0] a_q, b_q, c_q, res_q, wrk_res;
   logic              go_q, wrk_vld, accept;

   assign accept = start && (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)   state_d = BUSY;
         BUSY:    if (wrk_vld) state_d = DONE;
         DONE:    if (retire)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         go_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         go_q    <= accept;
         if (accept) begin
            a_q <= a;
            b_q <= b;
            c_q <= c;
         end
         // A worker result outside BUSY is ignored.
         if (state_q == BUSY && wrk_vld) res_q <= wrk_res;
      end
   end

   formula_worker #(
      .FORMULA (FORMULA),
      .IMPL    (IMPL)
   ) u_worker (
      .clk     (clk),
      .rst     (rst),
      .arg_vld (go_q),
      .a       (a_q),
      .b       (b_q),
      .c       (c_q),
      .res_vld (wrk_vld),
      .res     (wrk_res)
   );

   assign state = state_q;
   assign res   = res_q;

endmodule

// File: rtl/formula_distributor_inorder.sv
// Round-robin distributor over N_WORKERS formula slots with in-order result return,
// valid/ready on both sides and a registered occupancy count.
module formula_distributor_inorder
   import formula_distributor_pkg::*;
#(
   parameter int unsigned FORMULA   = 1,
   parameter int unsigned IMPL      = 1,
   parameter int unsigned N_WORKERS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           arg_vld,
   output logic                           arg_rdy,
   input  logic [DATA_W-1:0]              a,
   input  logic [DATA_W-1:0]              b,
   input  logic [DATA_W-1:0]              c,
   output logic                           res_vld,
   input  logic                           res_rdy,
   output logic [DATA_W-1:0]              res,
   output logic [$clog2(N_WORKERS+1)-1:0] in_flight
);

   localparam int unsigned PW = $clog2(N_WORKERS);
   localparam int unsigned CW = $clog2(N_WORKERS + 1);

   logic [PW-1:0]     issue_ptr_q, retire_ptr_q;
   logic [CW-1:0]     in_flight_q;
   slot_state_t       slot_st  [N_WORKERS];
   logic [DATA_W-1:0] slot_res [N_WORKERS];
   logic              transfer, retire;

   // Gating with rst keeps both handshakes quiet during the reset cycle itself.
   assign arg_rdy   = !rst && (slot_st[issue_ptr_q] == IDLE);
   assign res_vld   = !rst && (slot_st[retire_ptr_q] == DONE);
   assign res       = res_vld ? slot_res[retire_ptr_q] : '0;
   assign transfer  = arg_vld && arg_rdy;
   assign retire    = res_vld && res_rdy;
   assign in_flight = in_flight_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_ptr_q  <= '0;
         retire_ptr_q <= '0;
         in_flight_q  <= '0;
      end else begin
         if (transfer) issue_ptr_q <= PW'(ptr_next(32'(issue_ptr_q), N_WORKERS));
         if (retire) retire_ptr_q <= PW'(ptr_next(32'(retire_ptr_q), N_WORKERS));
         if (transfer && !retire) in_flight_q <= in_flight_q + 1'b1;
         else if (!transfer && retire) in_flight_q <= in_flight_q - 1'b1;
      end
   end

   for (genvar i = 0; i < N_WORKERS; i++) begin : g_slot
      formula_worker_slot #(
         .FORMULA (FORMULA),
         .IMPL    (IMPL)
      ) u_slot (
         .clk    (clk),
         .rst    (rst),
         .start  (transfer && (issue_ptr_q == PW'(i))),
         .retire (retire && (retire_ptr_q == PW'(i))),
         .a      (a),
         .b      (b),
         .c      (c),
         .state  (slot_st[i]),
         .res    (slot_res[i])
      );
   end

endmodule

// File: tb/tb_formula_distributor_inorder.sv
// Directed bench: DUT 0 is formula 1 (single-cycle worker, 4 slots), DUT 1 is formula 2 (5 slots).
module tb_formula_distributor_inorder;

   logic        clk;
   logic        rst;
   logic        arg_vld [2];
   logic        arg_rdy [2];
   logic [31:0] a [2];
   logic [31:0] b [2];
   logic [31:0] c [2];
   logic        res_vld [2];
   logic        res_rdy [2];
   logic [31:0] res [2];
   logic [2:0]  in_flight [2];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_ret [2];
   logic        hold_v [2];
   logic [31:0] hold_r [2];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

   formula_distributor_inorder #(
      .FORMULA (1), .IMPL (1), .N_WORKERS (4)
   ) dut0 (
      .clk (clk), .rst (rst), .arg_vld (arg_vld[0]), .arg_rdy (arg_rdy[0]),
      .a (a[0]), .b (b[0]), .c (c[0]), .res_vld (res_vld[0]), .res_rdy (res_rdy[0]),
      .res (res[0]), .in_flight (in_flight[0])
   );

   formula_distributor_inorder #(
      .FORMULA (2), .IMPL (1), .N_WORKERS (5)
   ) dut1 (
      .clk (clk), .rst (rst), .arg_vld (arg_vld[1]), .arg_rdy (arg_rdy[1]),
      .a (a[1]), .b (b[1]), .c (c[1]), .res_vld (res_vld[1]), .res_rdy (res_rdy[1]),
      .res (res[1]), .in_flight (in_flight[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1, "timeout");
   end

   // Binary-search square root, deliberately unlike the RTL's greedy method.
   function automatic logic [31:0] m_isqrt(input logic [31:0] x);
      logic [63:0] lo, hi, mid;
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= {32'd0, x}) lo = mid;
         else hi = mid - 1;
      end
      return lo[31:0];
   endfunction

   function automatic logic [31:0] model(input int d, input logic [31:0] av, bv, cv);
      if (d == 0) return m_isqrt(av) + m_isqrt(bv) + m_isqrt(cv);
      return m_isqrt(av + m_isqrt(bv + m_isqrt(cv)));
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle on DUT d, score handshakes against the model, then advance past the edge.
   task automatic cycle(input int d, input logic v, input logic [31:0] av, bv, cv,
                        input logic r, output logic acc);
      logic [31:0] e;
      arg_vld[d] = v;
      a[d] = av;
      b[d] = bv;
      c[d] = cv;
      res_rdy[d] = r;
      acc = v && arg_rdy[d];
      if (acc) begin
         if (d == 0) q0.push_back(model(0, av, bv, cv));
         else q1.push_back(model(1, av, bv, cv));
      end
      if (hold_v[d]) chk("res_stable", res[d], hold_r[d]);
      if (res_vld[d] && r) begin
         if (qsize(d) == 0) chk("retire_unexpected", res_vld[d], 1'b0);
         else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("retire_order", res[d], e);
         end
         n_ret[d]++;
      end
      hold_v[d] = res_vld[d] && !r;
      hold_r[d] = res[d];
      @(posedge clk);
      #1;
      arg_vld[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      logic acc;
      for (int i = 0; i < 200 && qsize(d) != 0; i++) cycle(d, 1'b0, 0, 0, 0, 1'b1, acc);
      chk("drain_empty", qsize(d), 0);
      chk("drain_in_flight", in_flight[d], 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         arg_vld[d] = 1'b0;
         res_rdy[d] = 1'b0;
         hold_v[d] = 1'b0;
         a[d] = 0;
         b[d] = 0;
         c[d] = 0;
      end
      q0.delete();
      q1.delete();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rst_arg_rdy0", arg_rdy[0], 1'b0);
      chk("rst_arg_rdy1", arg_rdy[1], 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("post_rst_arg_rdy", arg_rdy[d], 1'b1);
         chk("post_rst_res_vld", res_vld[d], 1'b0);
         chk("post_rst_res", res[d], 0);
         chk("post_rst_in_flight", in_flight[d], 0);
      end
   endtask

   logic [31:0] sa [6];
   logic [31:0] sb [6];
   logic [31:0] sc [6];

   initial begin
      logic        acc, pend;
      logic [31:0] pa, pb, pc;
      int          idx, nacc, ret0;

      n_ret[0] = 0;
      n_ret[1] = 0;
      do_reset();

      // Single formula-1 triple: isqrt 4 + 9 + 16 = 2 + 3 + 4.
      cycle(0, 1'b1, 4, 9, 16, 1'b1, acc);
      chk("basic_accept", acc, 1'b1);
      chk("basic_in_flight1", in_flight[0], 1);
      chk("basic_res_vld_early", res_vld[0], 1'b0);
      cycle(0, 1'b0, 0, 0, 0, 1'b1, acc);
      chk("basic_res_vld_T2", res_vld[0], 1'b0);
      cycle(0, 1'b0, 0, 0, 0, 1'b1, acc);
      chk("basic_res_vld_T3", res_vld[0], 1'b1);
      chk("basic_res", res[0], 9);
      chk("basic_arg_rdy", arg_rdy[0], 1'b1);
      cycle(0, 1'b0, 0, 0, 0, 1'b1, acc);
      chk("basic_in_flight0", in_flight[0], 0);
      chk("basic_res_vld_done", res_vld[0], 1'b0);

      // Formula 2: isqrt(6 + isqrt(6 + isqrt 9)) = 3, visible 4 edges after transfer.
      cycle(1, 1'b1, 6, 6, 9, 1'b0, acc);
      chk("f2_accept", acc, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1, 1'b0, 0, 0, 0, 1'b0, acc);
      chk("f2_res_vld_early", res_vld[1], 1'b0);
      cycle(1, 1'b0, 0, 0, 0, 1'b0, acc);
      chk("f2_res_vld", res_vld[1], 1'b1);
      chk("f2_res", res[1], 3);
      drain(1);

      // Full rate on 4 slots with a one-cycle worker.
      for (int i = 0; i < 100; i++) begin
         cycle(0, 1'b1, $urandom(), $urandom(), $urandom_range(0, 1000), 1'b1, acc);
         chk("fullrate_accept", acc, 1'b1);
      end
      drain(0);

      // Stall: six triples offered to four slots with the consumer blocked.
      sa = '{1, 16, 100, 2, 99, 65536};
      sb = '{4, 25, 0, 3, 120, 1};
      sc = '{9, 36, 0, 8, 143, 1};
      ret0 = n_ret[0];
      idx = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1'b1, sa[idx], sb[idx], sc[idx], 1'b0, acc);
         if (acc) idx++;
      end
      chk("stall_accepted", idx, 4);
      chk("stall_arg_rdy", arg_rdy[0], 1'b0);
      chk("stall_in_flight", in_flight[0], 4);
      chk("stall_res_vld", res_vld[0], 1'b1);
      chk("stall_res_head", res[0], 6);
      for (int i = 0; i < 40 && idx < 6; i++) begin
         cycle(0, 1'b1, sa[idx], sb[idx], sc[idx], 1'b1, acc);
         if (acc) idx++;
      end
      chk("stall_all_accepted", idx, 6);
      drain(0);
      chk("stall_retired", n_ret[0] - ret0, 6);

      // Random backpressure on five slots with a three-cycle worker.
      ret0 = n_ret[1];
      nacc = 0;
      pend = 1'b0;
      pa = 0;
      pb = 0;
      pc = 0;
      for (int i = 0; i < 200; i++) begin
         if (!pend && $urandom_range(0, 1) == 1) begin
            pa = $urandom();
            pb = $urandom();
            pc = $urandom();
            pend = 1'b1;
         end
         cycle(1, pend, pa, pb, pc, $urandom_range(0, 1) == 1, acc);
         if (acc) begin
            pend = 1'b0;
            nacc++;
         end
      end
      drain(1);
      chk("bp_count", n_ret[1] - ret0, nacc);

      // Reset with three tasks in flight.
      for (int i = 0; i < 3; i++) cycle(0, 1'b1, 49, 64, 81, 1'b0, acc);
      chk("midrst_in_flight", in_flight[0], 3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_res_vld", res_vld[0], 1'b0);
      chk("midrst_in_flight0", in_flight[0], 0);
      rst = 1'b0;
      q0.delete();
      hold_v[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("midrst_no_stale", res_vld[0], 1'b0);
         cycle(0, 1'b0, 0, 0, 0, 1'b1, acc);
      end
      cycle(0, 1'b1, 1, 1, 1, 1'b0, acc);
      chk("midrst_new_accept", acc, 1'b1);
      cycle(0, 1'b0, 0, 0, 0, 1'b0, acc);
      cycle(0, 1'b0, 0, 0, 0, 1'b0, acc);
      chk("midrst_new_vld", res_vld[0], 1'b1);
      chk("midrst_new_res", res[0], 3);
      drain(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
